// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (CPU, VIC) and memCtrl signals of the arbiter.
//   slave  - arbiter view: takes requests and memCtrl status, drives acks,
//            read data, error and the memCtrl strobe/address/data.
//   master - environment view: CPU/VIC bus logic and memCtrl.
interface mem_arbiter_if;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_ack;
  logic [7:0]  o_cpu_rdata;
  logic        i_vic_req;
  logic [13:0] i_vic_addr;
  logic        o_vic_ack;
  logic [7:0]  o_vic_rdata;
  logic        o_err;
  logic        o_mem_cs;
  logic        o_mem_write;
  logic [23:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;
  logic        i_mem_busy;
  logic        i_mem_data_ready;
  logic [2:0]  o_state;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  i_vic_req, i_vic_addr,
    input  i_mem_rdata, i_mem_busy, i_mem_data_ready,
    output o_cpu_ack, o_cpu_rdata, o_vic_ack, o_vic_rdata, o_err,
    output o_mem_cs, o_mem_write, o_mem_addr, o_mem_wdata, o_state
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output i_vic_req, i_vic_addr,
    output i_mem_rdata, i_mem_busy, i_mem_data_ready,
    input  o_cpu_ack, o_cpu_rdata, o_vic_ack, o_vic_rdata, o_err,
    input  o_mem_cs, o_mem_write, o_mem_addr, o_mem_wdata, o_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-request PSRAM controller between VIC and CPU.
//   clkSys - system clock
//   reset  - asynchronous active-high reset (memCtrl shares it)
//   bus    - slave side of mem_arbiter_if: CPU/VIC requests with one-cycle
//            acks and held read data, error pulse, memCtrl cs handshake,
//            debug state.
module mem_arbiter #(
  parameter logic [23:0] CPU_BASE = 24'h000000,
  parameter logic [23:0] VIC_BASE = 24'h010000,
  parameter int unsigned STARVE   = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input logic          clkSys,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  // Abort on the edge where the counter would reach TIMEOUT-1, which puts the
  // ack exactly TIMEOUT cycles after cs.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);
  localparam logic [7:0]    WAIT_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t          state, state_d;
  logic            load, pick_cpu, complete, expire;
  logic            gnt_vic;
  logic            mem_cs, mem_write;
  logic [23:0]     mem_addr;
  logic [7:0]      mem_wdata;
  logic            cpu_ack, vic_ack, err;
  logic [7:0]      cpu_rdata, vic_rdata;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      cpu_wait;
  logic            cpu_svc;

  // CPU counts as in service from grant until its ack cycle.
  assign cpu_svc = (state != IDLE) && !gnt_vic;

  // State register.
  always_ff @(posedge clkSys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d  = state;
    load     = 1'b0;
    pick_cpu = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_cpu_req || bus.i_vic_req) begin
          load     = 1'b1;
          pick_cpu = bus.i_cpu_req && (!bus.i_vic_req || (cpu_wait >= 8'(STARVE)));
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        // Busy only moves us on; it is not completion, so timeout wins here.
        if (tmo_cnt == TMO_LAST) begin
          expire  = 1'b1;
          state_d = RESP;
        end else if (bus.i_mem_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mem_write ? !bus.i_mem_busy : bus.i_mem_data_ready) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered datapath, strobes and counters.
  always_ff @(posedge clkSys or posedge reset) begin
    if (reset) begin
      gnt_vic   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 24'h0;
      mem_wdata <= 8'h0;
      cpu_ack   <= 1'b0;
      vic_ack   <= 1'b0;
      err       <= 1'b0;
      cpu_rdata <= 8'h0;
      vic_rdata <= 8'h0;
      tmo_cnt   <= '0;
      cpu_wait  <= 8'h0;
    end else begin
      mem_cs  <= (state_d == ISSUE);
      cpu_ack <= (state_d == RESP) && !gnt_vic;
      vic_ack <= (state_d == RESP) && gnt_vic;
      // RESP is entered only on completion or expiry, so this is the error flag.
      err     <= expire;

      if (load) begin
        gnt_vic   <= !pick_cpu;
        mem_write <= pick_cpu && bus.i_cpu_we;
        mem_addr  <= pick_cpu ? (CPU_BASE + 24'(bus.i_cpu_addr))
                              : (VIC_BASE + 24'(bus.i_vic_addr));
        mem_wdata <= pick_cpu ? bus.i_cpu_wdata : 8'h00;
      end

      if (state == ISSUE)
        tmo_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        tmo_cnt <= tmo_cnt + TW'(1);

      if (complete && !mem_write) begin
        if (gnt_vic) vic_rdata <= bus.i_mem_rdata;
        else         cpu_rdata <= bus.i_mem_rdata;
      end else if (expire) begin
        if (gnt_vic) vic_rdata <= 8'hFF;
        else         cpu_rdata <= 8'hFF;
      end

      if (load && pick_cpu)
        cpu_wait <= 8'h0;
      else if (bus.i_cpu_req && !cpu_svc && cpu_wait != WAIT_MAX)
        cpu_wait <= cpu_wait + 8'd1;
    end
  end

  assign bus.o_state     = state;
  assign bus.o_mem_cs    = mem_cs;
  assign bus.o_mem_write = mem_write;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_cpu_ack   = cpu_ack;
  assign bus.o_vic_ack   = vic_ack;
  assign bus.o_err       = err;
  assign bus.o_cpu_rdata = cpu_rdata;
  assign bus.o_vic_rdata = vic_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized accesses against a cycle-count
// reference model of the arbiter (grant rule, address map, ack timing,
// read-data/error results) with a scripted memCtrl responder.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned STARVE   = 8;
  localparam logic [23:0] CPU_BASE = 24'h000000;
  localparam logic [23:0] VIC_BASE = 24'h010000;

  logic clkSys = 1'b0;
  logic reset  = 1'b1;
  always #5 clkSys = ~clkSys;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .CPU_BASE(CPU_BASE),
    .VIC_BASE(VIC_BASE),
    .STARVE  (STARVE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clkSys(clkSys),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int         m_wait = 0;
  bit         m_cpu_svc = 1'b0;
  bit         m_grant_cpu_now = 1'b0;
  logic [7:0] m_cpu_rd = 8'h00;
  logic [7:0] m_vic_rd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the CPU wait count follows the cycle's request level.
  task automatic tick();
    if (m_grant_cpu_now) m_wait = 0;
    else if (bus.i_cpu_req && !m_cpu_svc && m_wait < 255) m_wait++;
    @(posedge clkSys);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(bus.o_state), 32'd0);
    chk({tag, "_cs"},    32'(bus.o_mem_cs), 32'd0);
    chk({tag, "_acks"},  32'({bus.o_cpu_ack, bus.o_vic_ack, bus.o_err}), 32'd0);
    chk({tag, "_addr"},  32'(bus.o_mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'({bus.o_mem_write, bus.o_mem_wdata}), 32'd0);
    chk({tag, "_rdata"}, 32'({bus.o_cpu_rdata, bus.o_vic_rdata}), 32'd0);
  endtask

  // One access starting in an IDLE cycle with requests already driven.
  // bd: cycles from cs to busy; dd: busy-to-completion cycles; hang: never busy.
  task automatic run_access(input int bd, input int dd, input bit hang,
                            input bit glitch, input logic [7:0] rd,
                            input bit keep_cpu, input bit keep_vic,
                            output bit got_cpu);
    bit          exp_cpu, ew;
    int unsigned a;
    logic [23:0] ea;
    logic [7:0]  ewd, rd_exp;
    int          bs, comp, ack_c;

    chk("idle_state", 32'(bus.o_state), 32'd0);
    exp_cpu = bus.i_cpu_req && (!bus.i_vic_req || m_wait >= int'(STARVE));
    if (exp_cpu) a = 32'(CPU_BASE) + 32'(bus.i_cpu_addr);
    else         a = 32'(VIC_BASE) + 32'(bus.i_vic_addr);
    ea      = 24'(a % 32'h0100_0000);
    ew      = exp_cpu && bus.i_cpu_we;
    ewd     = bus.i_cpu_wdata;
    got_cpu = exp_cpu;
    bs      = 1 + bd;
    comp    = hang ? -1 : bs + dd;
    ack_c   = hang ? 1 + int'(TIMEOUT) : comp + 1;
    rd_exp  = hang ? 8'hFF : rd;

    m_grant_cpu_now = exp_cpu;
    tick();
    m_grant_cpu_now = 1'b0;
    m_cpu_svc = exp_cpu;

    chk("cs",        32'(bus.o_mem_cs), 32'd1);
    chk("cs_addr",   32'(bus.o_mem_addr), 32'(ea));
    chk("cs_write",  32'(bus.o_mem_write), 32'(ew));
    if (ew) chk("cs_wdata", 32'(bus.o_mem_wdata), 32'(ewd));
    chk("issue_state", 32'(bus.o_state), 32'd1);

    // Requester fields changing mid-access must not matter.
    bus.i_cpu_addr  = 16'($urandom);
    bus.i_cpu_wdata = 8'($urandom);
    bus.i_cpu_we    = 1'($urandom);
    bus.i_vic_addr  = 14'($urandom);

    for (int c = 1; c < ack_c; c++) begin
      bus.i_mem_busy       = !hang && (ew ? (c >= bs && c < comp) : (c >= bs && c <= comp));
      bus.i_mem_data_ready = !hang && ((!ew && c == comp) || (glitch && c == 2 && bs > 2));
      bus.i_mem_rdata      = (!ew && c == comp) ? rd_exp : 8'($urandom);
      tick();
      if (c + 1 < ack_c) begin
        chk("no_early_ack", 32'({bus.o_cpu_ack, bus.o_vic_ack}), 32'd0);
        chk("single_cs",    32'(bus.o_mem_cs), 32'd0);
      end
    end
    bus.i_mem_busy       = 1'b0;
    bus.i_mem_data_ready = 1'b0;

    chk("ack_cpu",    32'(bus.o_cpu_ack), 32'(exp_cpu));
    chk("ack_vic",    32'(bus.o_vic_ack), 32'(!exp_cpu));
    chk("ack_err",    32'(bus.o_err), 32'(hang));
    chk("resp_state", 32'(bus.o_state), 32'd4);
    if (hang || !ew) begin
      if (exp_cpu) m_cpu_rd = rd_exp;
      else         m_vic_rd = rd_exp;
    end
    chk("cpu_rdata", 32'(bus.o_cpu_rdata), 32'(m_cpu_rd));
    chk("vic_rdata", 32'(bus.o_vic_rdata), 32'(m_vic_rd));

    tick();
    m_cpu_svc = 1'b0;
    if (exp_cpu && !keep_cpu) bus.i_cpu_req = 1'b0;
    if (!exp_cpu && !keep_vic) bus.i_vic_req = 1'b0;
    chk("ack_pulse", 32'({bus.o_cpu_ack, bus.o_vic_ack, bus.o_err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n_vic;

    bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h0; bus.i_cpu_wdata = 8'h0;
    bus.i_vic_req = 1'b0; bus.i_vic_addr = 14'h0;
    bus.i_mem_rdata = 8'h0; bus.i_mem_busy = 1'b0; bus.i_mem_data_ready = 1'b0;

    repeat (2) @(posedge clkSys);
    #1;
    chk_reset("rst");
    reset = 1'b0;
    tick();

    // CPU read of the top of CPU space; data ready three cycles after cs.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'hFFFC;
    run_access(1, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, got);

    // CPU write.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 16'hD020; bus.i_cpu_wdata = 8'h05;
    run_access(1, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, got);

    // Simultaneous requests: VIC first, then CPU.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h0300;
    bus.i_vic_req = 1'b1; bus.i_vic_addr = 14'h3FFF;
    run_access(1, 1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, got);
    chk("simul_first_vic", 32'(got), 32'd0);
    run_access(2, 1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, got);
    chk("simul_then_cpu", 32'(got), 32'd1);

    // Starvation: both held at minimum latency; CPU wins after two VIC accesses.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h1000;
    bus.i_vic_req = 1'b1; bus.i_vic_addr = 14'h0123;
    n_vic = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      bus.i_cpu_addr = 16'h1000;
      run_access(1, 1, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1, got);
      if (!got) n_vic++;
    end
    chk("starve_cpu_granted", 32'(got), 32'd1);
    chk("starve_vic_count", 32'(n_vic), 32'd2);
    run_access(1, 1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, got);
    chk("starve_vic_after", 32'(got), 32'd0);

    // Timeout: memCtrl never goes busy.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h0042;
    run_access(1, 1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, got);

    // Reset in WAIT_DONE.
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h1234;
    tick();
    tick();
    bus.i_mem_busy = 1'b1;
    tick();
    chk("pre_reset_state", 32'(bus.o_state), 32'd3);
    reset = 1'b1;
    #1;
    chk_reset("midrst");
    m_wait = 0; m_cpu_svc = 1'b0; m_cpu_rd = 8'h00; m_vic_rd = 8'h00;
    bus.i_cpu_req = 1'b0; bus.i_mem_busy = 1'b0;
    @(posedge clkSys);
    #1;
    reset = 1'b0;
    tick();
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h5678;
    run_access(1, 1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, got);

    // Randomized accesses.
    for (int k = 0; k < 30; k++) begin
      int r;
      r = int'($urandom_range(1, 3));
      if (r[0]) bus.i_cpu_req = 1'b1;
      if (r[1]) bus.i_vic_req = 1'b1;
      bus.i_cpu_we    = 1'($urandom);
      bus.i_cpu_addr  = 16'($urandom);
      bus.i_cpu_wdata = 8'($urandom);
      bus.i_vic_addr  = 14'($urandom);
      run_access(int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
                 ($urandom_range(0, 11) == 0), 1'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
